cw_capture_buf: RTL and testbench

//  Sample store downstream of the watcher core. Consumes its write strobes (wt_ce/wt_en/wt_addr)

---
 rtl/cw_capture_buf.sv | 150 +++++++++++++++
 tb/tb_cw_capture_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cw_capture_buf.sv
// Capture buffer: stores watcher write strobes into a sample RAM, one capture per arm,
// with a 2-cycle pipelined read port. Optional stored parity via CW_CAPBUF_PARITY_EN.
module cw_capture_buf #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                trig_clk,
  input  logic                trig_rst,
  input  logic                arm,
  input  logic [DATA_W-1:0]   sample_din,
  input  logic                wt_ce,
  input  logic                wt_en,
  input  logic [15:0]         wt_addr,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_perr,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     wr_count,
  output logic [ADDR_W-1:0]   last_addr,
  output logic                ovf
);

  // state   | meaning
  // IDLE    | after reset, strobes ignored until arm
  // CAPTURE | accepting watcher writes
  // DONE    | capture finished, waiting for re-arm
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);
  localparam logic [16:0]      DEPTH_17 = 17'(DEPTH);
`ifdef CW_CAPBUF_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_t state_q, state_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_v1_q, rd_v1_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              strobe, in_range, accept, drop;
  logic [RAM_W-1:0]  wr_word;
  logic [RAM_W-1:0]  mem [2**ADDR_W];
  logic [RAM_W-1:0]  mem_rd_q;

`ifdef CW_CAPBUF_PARITY_EN
  logic rd_perr_q, rd_perr_d;
  assign wr_word   = {^sample_din, sample_din};
  assign rd_perr_d = rd_v1_q & (^mem_rd_q);
  assign rd_perr   = rd_perr_q;
`else
  assign wr_word = sample_din;
  assign rd_perr = 1'b0;
`endif

  // Full 16-bit compare so aliased high addresses are dropped, not wrapped.
  assign strobe   = wt_ce & wt_en;
  assign in_range = {1'b0, wt_addr} < DEPTH_17;
  assign accept   = (state_q == CAPTURE) & strobe & in_range;
  assign drop     = (state_q == CAPTURE) & strobe & ~in_range;

  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    last_addr_d = last_addr_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d     = CAPTURE;
          wr_count_d  = '0;
          last_addr_d = '0;
          ovf_d       = 1'b0;
        end
      end
      CAPTURE: begin
        if (accept) begin
          if (wr_count_q < DEPTH_C) wr_count_d = wr_count_q + 1'b1;
          last_addr_d = wt_addr[ADDR_W-1:0];
          if (wr_count_q == DEPTH_M1) state_d = DONE;
        end
        if (drop) ovf_d = 1'b1;
        // Trigger window closes once the watcher stops after at least one sample.
        if (!wt_en && wr_count_q != '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == CAPTURE);
    done_d     = (state_d == DONE);
    rd_v1_d    = rd_req;
    rd_valid_d = rd_v1_q;
    rd_data_d  = rd_v1_q ? mem_rd_q[DATA_W-1:0] : rd_data_q;
  end

  always_ff @(posedge trig_clk) begin
    if (trig_rst) begin
      state_q     <= IDLE;
      wr_count_q  <= '0;
      last_addr_q <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_v1_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
`ifdef CW_CAPBUF_PARITY_EN
      rd_perr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      last_addr_q <= last_addr_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_v1_q     <= rd_v1_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
`ifdef CW_CAPBUF_PARITY_EN
      rd_perr_q   <= rd_perr_d;
`endif
    end
  end

  // Read-first RAM: a same-edge write to rd_addr is not visible to this read.
  always_ff @(posedge trig_clk) begin
    if (accept) mem[wt_addr[ADDR_W-1:0]] <= wr_word;
    mem_rd_q <= mem[rd_addr];
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_count  = wr_count_q;
  assign last_addr = last_addr_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cw_capture_buf.sv
// Directed bench for cw_capture_buf: default-depth instance plus a DEPTH=16 instance
// sharing the same stimulus. Parity corruption check runs when CW_CAPBUF_PARITY_EN is set.
module tb_cw_capture_buf;
  logic        clk = 1'b0;
  logic        trig_rst, arm, wt_ce, wt_en, rd_req;
  logic [9:0]  sample_din, rd_addr;
  logic [15:0] wt_addr;

  logic        rd_valid, rd_perr, busy, done, ovf;
  logic [9:0]  rd_data, last_addr;
  logic [10:0] wr_count;
  logic        s_rd_valid, s_rd_perr, s_busy, s_done, s_ovf;
  logic [9:0]  s_rd_data;
  logic [3:0]  s_last_addr;
  logic [4:0]  s_wr_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cw_capture_buf dut (
    .trig_clk(clk), .trig_rst(trig_rst), .arm(arm), .sample_din(sample_din),
    .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr), .busy(busy), .done(done),
    .wr_count(wr_count), .last_addr(last_addr), .ovf(ovf));

  cw_capture_buf #(.DATA_W(10), .ADDR_W(4), .DEPTH(16)) dut16 (
    .trig_clk(clk), .trig_rst(trig_rst), .arm(arm), .sample_din(sample_din),
    .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr), .rd_req(rd_req), .rd_addr(rd_addr[3:0]),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_perr(s_rd_perr), .busy(s_busy),
    .done(s_done), .wr_count(s_wr_count), .last_addr(s_last_addr), .ovf(s_ovf));

  typedef struct {
    logic       req;
    logic [9:0] addr;
    logic       exp_v;
    logic [9:0] exp_d;
  } rd_vec_t;
  rd_vec_t rv[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [9:0] d);
    wt_ce = 1'b1; wt_en = 1'b1; wt_addr = a; sample_din = d;
    tick();
  endtask

  initial begin
    // Each row: request driven this cycle, outputs expected after this cycle's edge.
    rv[0] = '{1'b1, 10'd0, 1'b0, 10'h000};
    rv[1] = '{1'b1, 10'd1, 1'b1, 10'h3A0};
    rv[2] = '{1'b1, 10'd2, 1'b1, 10'h3A1};
    rv[3] = '{1'b1, 10'd3, 1'b1, 10'h3A2};
    rv[4] = '{1'b1, 10'd4, 1'b1, 10'h3A3};
    rv[5] = '{1'b0, 10'd0, 1'b1, 10'h3A4};
    rv[6] = '{1'b0, 10'd0, 1'b0, 10'h3A4};
    rv[7] = '{1'b1, 10'd2, 1'b0, 10'h3A4};
    rv[8] = '{1'b0, 10'd0, 1'b1, 10'h3A2};
    rv[9] = '{1'b0, 10'd0, 1'b0, 10'h3A2};

    trig_rst = 1'b1; arm = 1'b0; wt_ce = 1'b0; wt_en = 1'b0; wt_addr = '0;
    sample_din = '0; rd_req = 1'b0; rd_addr = '0;
    tick(); tick();
    trig_rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_wr_count", wr_count, 0); chk("rst_last_addr", last_addr, 0);
    chk("rst_ovf", ovf, 0);        chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0); chk("rst_rd_perr", rd_perr, 0);

    // Basic capture of five samples then trigger release.
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 5; i++) wr(16'(i), 10'(10'h3A0 + i));
    wt_ce = 1'b0; wt_en = 1'b0; tick();
    chk("t1_done", done, 1);  chk("t1_busy_off", busy, 0);
    chk("t1_wr_count", wr_count, 5); chk("t1_last_addr", last_addr, 4);

    for (int i = 0; i < 10; i++) begin
      rd_req = rv[i].req; rd_addr = rv[i].addr;
      tick();
      chk($sformatf("t1_rd_valid[%0d]", i), rd_valid, rv[i].exp_v);
      chk($sformatf("t1_rd_data[%0d]", i), rd_data, rv[i].exp_d);
      chk($sformatf("t1_rd_perr[%0d]", i), rd_perr, 0);
    end

    // DEPTH=16 instance fills up and closes on its 16th write.
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(16'(i), 10'(10'h100 + i));
      if (i == 14) begin
        chk("t2_done_before_full", s_done, 0);
        chk("t2_count_15", s_wr_count, 15);
      end
    end
    chk("t2_done_full", s_done, 1); chk("t2_busy_full", s_busy, 0);
    chk("t2_wr_count", s_wr_count, 16); chk("t2_last_addr", s_last_addr, 15);
    wr(16'd0, 10'h3FF);
    chk("t2_wr_count_17th", s_wr_count, 16); chk("t2_ovf_17th", s_ovf, 0);
    chk("t2_big_count_17", wr_count, 17);
    wt_ce = 1'b0; wt_en = 1'b0;
    rd_req = 1'b1; rd_addr = 10'd0; tick(); rd_req = 1'b0; tick();
    chk("t2_rd_valid", s_rd_valid, 1); chk("t2_ram0_kept", s_rd_data, 10'h100);
    chk("t2_big_ram0", rd_data, 10'h3FF);
    chk("t2_big_done", done, 1);

    // Out-of-range writes are dropped and flagged.
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t3_count_clear", wr_count, 0); chk("t3_done_clear", done, 0);
    wr(16'd5, 10'h155);
    wr(16'h0400, 10'h2AA);
    chk("t3_ovf", ovf, 1); chk("t3_count_after_drop", wr_count, 1);
    wr(16'h8005, 10'h0EE);
    chk("t3_alias_count", wr_count, 1); chk("t3_alias_last", last_addr, 5);
    wr(16'd1023, 10'h1C3);
    chk("t3_top_count", wr_count, 2); chk("t3_top_last", last_addr, 10'h3FF);
    wt_ce = 1'b0; wt_en = 1'b0; tick();
    chk("t3_done", done, 1); chk("t3_ovf_sticky", ovf, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t3_ovf_cleared", ovf, 0); chk("t3_rearm_count", wr_count, 0);
    chk("t3_rearm_busy", busy, 1);

    // Same-cycle read and write to one address returns the old data.
    wr(16'd7, 10'h011);
    rd_req = 1'b1; rd_addr = 10'd7;
    wr(16'd7, 10'h2FF);
    wt_ce = 1'b0; wt_en = 1'b1; rd_addr = 10'd7; tick();
    chk("t4_rd_valid", rd_valid, 1); chk("t4_read_first", rd_data, 10'h011);
    rd_addr = 10'd5; tick();
    chk("t4_new_data", rd_data, 10'h2FF);
    rd_req = 1'b0; tick();
    chk("t4_alias_not_written", rd_data, 10'h155);
    wt_en = 1'b0; tick();
    chk("t4_done", done, 1); chk("t4_wr_count", wr_count, 2); chk("t4_last_addr", last_addr, 7);

    // Reset mid-capture with a read in flight.
    arm = 1'b1; tick(); arm = 1'b0;
    wr(16'd3, 10'h0AA);
    wt_ce = 1'b0; wt_en = 1'b1; rd_req = 1'b1; rd_addr = 10'd3; tick();
    rd_req = 1'b0; trig_rst = 1'b1; tick();
    chk("t5_rd_valid", rd_valid, 0); chk("t5_rd_data", rd_data, 0);
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_wr_count", wr_count, 0);
    chk("t5_last_addr", last_addr, 0); chk("t5_ovf", ovf, 0);
    trig_rst = 1'b0; tick();
    chk("t5_no_late_valid", rd_valid, 0);
    wr(16'd3, 10'h001);
    wt_ce = 1'b0; wt_en = 1'b0; tick();
    chk("t5_idle_busy", busy, 0); chk("t5_idle_count", wr_count, 0);
    chk("t5_idle_done", done, 0);
    rd_req = 1'b1; rd_addr = 10'd3; tick(); rd_req = 1'b0; tick();
    chk("t5_ram_kept_valid", rd_valid, 1); chk("t5_ram_kept", rd_data, 10'h0AA);
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick(); tick();
    chk("t5_wait_trigger_busy", busy, 1); chk("t5_wait_trigger_done", done, 0);

`ifdef CW_CAPBUF_PARITY_EN
    dut.mem[3] = dut.mem[3] ^ 11'h001;
    rd_req = 1'b1; rd_addr = 10'd3; tick();
    rd_addr = 10'd4; tick();
    chk("t6_valid_bad", rd_valid, 1); chk("t6_perr_bad", rd_perr, 1);
    chk("t6_data_bad", rd_data, 10'h0AB);
    rd_req = 1'b0; tick();
    chk("t6_valid_good", rd_valid, 1); chk("t6_perr_good", rd_perr, 0);
    chk("t6_data_good", rd_data, 10'h104);
    tick();
    chk("t6_perr_idle", rd_perr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
